// File: rtl/bus_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin bus scheduler.
package bus_sched_pkg;

  // Header destination ID width, taken from the top bits of each packet.
  localparam int unsigned ID_W = 8;

  // Upper bound on the number of drivers; masks are built at this width and sliced.
  localparam int unsigned MaxDrvrs = 16;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StPush,
    StGap
  } state_t;

  // Destination push mask for a packet from driver src. An all-zero result marks
  // an invalid destination (broadcast can never produce zero because drvrs >= 2).
  function automatic logic [MaxDrvrs-1:0] dst_mask(input logic [ID_W-1:0] dst,
                                                   input logic [3:0]      src,
                                                   input int unsigned     drvrs,
                                                   input logic [ID_W-1:0] bcast);
    logic [MaxDrvrs-1:0] m;
    m = '0;
    if (dst == bcast) begin
      for (int unsigned i = 0; i < MaxDrvrs; i++) begin
        m[i] = (i < drvrs) && (i != 32'(src));
      end
    end else if (32'(dst) < drvrs) begin
      m[dst[3:0]] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/bus_rr_scheduler_if.sv
// Bus between the per-driver FIFOs and the scheduler.
interface bus_rr_scheduler_if #(
  parameter int unsigned drvrs   = 4,
  parameter int unsigned pckg_sz = 16
);

  logic [drvrs-1:0]         pndng;
  logic [drvrs*pckg_sz-1:0] D_pop;
  logic [drvrs-1:0]         pop;
  logic [drvrs-1:0]         push;
  logic [pckg_sz-1:0]       D_push;
  logic [3:0]               grant_id;
  logic                     busy;
  logic                     err;
  logic [15:0]              pkt_cnt;

  // Scheduler side.
  modport master (
    input  pndng, D_pop,
    output pop, push, D_push, grant_id, busy, err, pkt_cnt
  );

  // FIFO side.
  modport slave (
    output pndng, D_pop,
    input  pop, push, D_push, grant_id, busy, err, pkt_cnt
  );

endinterface

// File: rtl/bus_rr_scheduler_rr_arbiter.sv
// Combinational rotate-priority pick: first request strictly after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned drvrs = 4
) (
  input  logic [drvrs-1:0] req_i,
  input  logic [3:0]       ptr_i,
  output logic [3:0]       gnt_idx_o,
  output logic             gnt_valid_o
);

  // Two passes: indices above ptr first, then the wrapped range 0..ptr.
  always_comb begin
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int unsigned i = 0; i < drvrs; i++) begin
      if (!gnt_valid_o && req_i[i] && (i > 32'(ptr_i))) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = 4'(i);
      end
    end
    for (int unsigned i = 0; i < drvrs; i++) begin
      if (!gnt_valid_o && req_i[i] && (i <= 32'(ptr_i))) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = 4'(i);
      end
    end
  end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler/router: pops one source FIFO, routes its packet to the
// destination FIFO (or all others on broadcast).
module bus_rr_scheduler
  import bus_sched_pkg::*;
#(
  parameter int unsigned     drvrs     = 4,
  parameter int unsigned     pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = 8'hFF,
  parameter int unsigned     GAP       = 0
) (
  input logic                clk,
  input logic                reset,
  bus_rr_scheduler_if.master bus_io
);

  state_t               state_q, state_d;
  logic [3:0]           rr_ptr_q, rr_ptr_d;
  logic [3:0]           grant_q, grant_d;
  logic [3:0]           gap_q, gap_d;
  logic [pckg_sz-1:0]   pkt_q, pkt_d;
  logic [drvrs-1:0]     pop_q, pop_d;
  logic [drvrs-1:0]     push_q, push_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic [15:0]          pkt_cnt_q, pkt_cnt_d;

  logic [3:0]           arb_idx;
  logic                 arb_valid;
  logic [pckg_sz-1:0]   head;
  logic [MaxDrvrs-1:0]  dst_full;
  logic [drvrs-1:0]     dst_sel;

  rr_arbiter #(
    .drvrs(drvrs)
  ) u_rr_arbiter (
    .req_i      (bus_io.pndng),
    .ptr_i      (rr_ptr_q),
    .gnt_idx_o  (arb_idx),
    .gnt_valid_o(arb_valid)
  );

  // Head packet of the granted FIFO and its decoded destination mask.
  assign head     = bus_io.D_pop[32'(grant_q) * pckg_sz +: pckg_sz];
  assign dst_full = dst_mask(head[pckg_sz-1 -: ID_W], grant_q, drvrs, broadcast);
  assign dst_sel  = dst_full[drvrs-1:0];

  // State and registered outputs; reset abandons any in-flight packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      rr_ptr_q  <= 4'(drvrs - 1);
      grant_q   <= '0;
      gap_q     <= '0;
      pkt_q     <= '0;
      pop_q     <= '0;
      push_q    <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      gap_q     <= gap_d;
      pkt_q     <= pkt_d;
      pop_q     <= pop_d;
      push_q    <= push_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // Next state; strobes are computed one state early so they appear registered.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    gap_d     = gap_q;
    pkt_d     = pkt_q;
    pop_d     = '0;
    push_d    = '0;
    err_d     = 1'b0;
    pkt_cnt_d = pkt_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          grant_d = arb_idx;
          pop_d   = {{(drvrs-1){1'b0}}, 1'b1} << arb_idx;
          state_d = StGrant;
        end
      end
      StGrant: begin
        pkt_d    = head;
        rr_ptr_d = grant_q;
        push_d   = dst_sel;
        err_d    = ~|dst_sel;
        state_d  = StPush;
      end
      StPush: begin
        if (|push_q) begin
          pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
        if (GAP != 0) begin
          gap_d   = '0;
          state_d = StGap;
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (32'(gap_q) >= GAP - 1) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  assign bus_io.pop      = pop_q;
  assign bus_io.push     = push_q;
  assign bus_io.D_push   = pkt_q;
  assign bus_io.grant_id = grant_q;
  assign bus_io.busy     = busy_q;
  assign bus_io.err      = err_q;
  assign bus_io.pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Scoreboard bench for bus_rr_scheduler: directed packets through modelled FIFOs.
module tb_bus_rr_scheduler;

  localparam int unsigned Drvrs = 4;
  localparam int unsigned PkSz  = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  bus_rr_scheduler_if #(.drvrs(Drvrs), .pckg_sz(PkSz)) bus ();

  bus_rr_scheduler #(
    .drvrs    (Drvrs),
    .pckg_sz  (PkSz),
    .broadcast(8'hFF),
    .GAP      (0)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus_io(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model
  logic [15:0] fifo_mem [Drvrs][16];
  int unsigned wr_ptr [Drvrs];
  int unsigned rd_ptr [Drvrs];

  // Scoreboard queues
  int          exp_src_q  [$];
  logic [3:0]  exp_mask_q [$];
  logic [15:0] exp_data_q [$];
  logic        exp_err_q  [$];
  int unsigned pop_times  [$];
  int unsigned push_times [$];

  logic [15:0] t4_pkt  [8];
  logic [3:0]  t4_mask [8];
  int unsigned t0;

  function automatic void check(string what, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", what, got, exp, cyc);
    end
  endfunction

  task automatic refresh();
    for (int i = 0; i < Drvrs; i++) begin
      bus.pndng[i] = (rd_ptr[i] != wr_ptr[i]);
      bus.D_pop[i*PkSz +: PkSz] = (rd_ptr[i] != wr_ptr[i]) ? fifo_mem[i][rd_ptr[i] % 16] : 16'h0;
    end
  endtask

  task automatic enqueue(input int src, input logic [15:0] data);
    fifo_mem[src][wr_ptr[src] % 16] = data;
    wr_ptr[src]++;
    refresh();
  endtask

  task automatic expect_pkt(input int src, input logic [3:0] mask, input logic [15:0] data,
                            input logic err);
    exp_src_q.push_back(src);
    exp_mask_q.push_back(mask);
    exp_data_q.push_back(data);
    exp_err_q.push_back(err);
  endtask

  // One clock: note pop mid-cycle, retire FIFO heads just after the edge.
  task automatic tick();
    logic [3:0] popped;
    @(negedge clk);
    popped = bus.pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < Drvrs; i++) begin
      if (popped[i] && rd_ptr[i] != wr_ptr[i]) rd_ptr[i]++;
    end
    refresh();
  endtask

  // Monitor: compare every pop and push/err event against the scoreboard.
  initial begin
    int          src;
    logic [3:0]  m;
    logic [15:0] d;
    logic        e;
    forever begin
      @(negedge clk);
      if (bus.pop != 0) begin
        pop_times.push_back(cyc);
        if (exp_src_q.size() == 0) begin
          check("pop_unexpected", 32'(bus.pop), 32'h0);
        end else begin
          src = exp_src_q.pop_front();
          check("pop_mask", 32'(bus.pop), 32'(4'b0001 << src));
          check("grant_id", 32'(bus.grant_id), 32'(src));
        end
      end
      if (bus.push != 0 || bus.err) begin
        push_times.push_back(cyc);
        if (exp_mask_q.size() == 0) begin
          check("push_unexpected", {bus.err, 27'h0, bus.push}, 32'h0);
        end else begin
          m = exp_mask_q.pop_front();
          d = exp_data_q.pop_front();
          e = exp_err_q.pop_front();
          check("push_mask", 32'(bus.push), 32'(m));
          check("d_push", 32'(bus.D_push), 32'(d));
          check("err", 32'(bus.err), 32'(e));
        end
      end
      if (bus.pop != 0 && bus.push != 0) check("pop_push_overlap", 32'(bus.pop & bus.push), 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    bus.pndng = '0;
    bus.D_pop = '0;
    for (int i = 0; i < Drvrs; i++) begin
      wr_ptr[i] = 0;
      rd_ptr[i] = 0;
    end
    t4_pkt  = '{16'h0100, 16'h0210, 16'h0320, 16'h0030, 16'h0201, 16'h0311, 16'h0021, 16'h0131};
    t4_mask = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    // Reset with every driver pending, then full rotation 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) begin
      enqueue(k % 4, t4_pkt[k]);
      expect_pkt(k % 4, t4_mask[k], t4_pkt[k], 1'b0);
    end
    repeat (3) tick();
    check("rst_pop", 32'(bus.pop), 32'h0);
    check("rst_push", 32'(bus.push), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_pkt_cnt", 32'(bus.pkt_cnt), 32'h0);
    check("rst_d_push", 32'(bus.D_push), 32'h0);
    pop_times.delete();
    rst_n = 1'b1;
    t0 = cyc;
    repeat (28) tick();
    check("rot_pop_count", pop_times.size(), 32'd8);
    if (pop_times.size() == 8) begin
      check("rot_first_pop_cycle", pop_times[0], t0 + 1);
      for (int k = 1; k < 8; k++) check("rot_pop_spacing", pop_times[k] - pop_times[k-1], 32'd3);
    end
    check("rot_pkt_cnt", 32'(bus.pkt_cnt), 32'd8);
    check("rot_busy_idle", 32'(bus.busy), 32'h0);

    // Single unicast from driver 2: latency pop N+1, push N+2.
    pop_times.delete();
    push_times.delete();
    expect_pkt(2, 4'b0010, 16'h01AB, 1'b0);
    t0 = cyc;
    enqueue(2, 16'h01AB);
    repeat (5) tick();
    check("uc_pop_seen", pop_times.size(), 32'd1);
    check("uc_push_seen", push_times.size(), 32'd1);
    if (pop_times.size() == 1) check("uc_pop_latency", pop_times[0], t0 + 1);
    if (push_times.size() == 1) check("uc_push_latency", push_times[0], t0 + 2);
    check("uc_pkt_cnt", 32'(bus.pkt_cnt), 32'd9);

    // Broadcast from driver 1: everyone but the source, exactly one cycle.
    push_times.delete();
    expect_pkt(1, 4'b1101, 16'hFF55, 1'b0);
    enqueue(1, 16'hFF55);
    repeat (5) tick();
    check("bc_push_cycles", push_times.size(), 32'd1);
    check("bc_pkt_cnt", 32'(bus.pkt_cnt), 32'd10);

    // Invalid destination 7 from driver 3: popped, err pulse, no delivery.
    push_times.delete();
    expect_pkt(3, 4'b0000, 16'h07AA, 1'b1);
    enqueue(3, 16'h07AA);
    repeat (5) tick();
    check("inv_err_cycles", push_times.size(), 32'd1);
    check("inv_pkt_cnt", 32'(bus.pkt_cnt), 32'd10);
    check("inv_fifo_drained", 32'(bus.pndng), 32'h0);

    // Reset asserted during PUSH clears push at once; no strobes afterwards.
    exp_src_q.push_back(0);
    enqueue(0, 16'h0102);
    tick();
    tick();
    check("pre_rst_push", 32'(bus.push), 32'b0010);
    rst_n = 1'b0;
    #1;
    check("mid_rst_push", 32'(bus.push), 32'h0);
    check("mid_rst_pop", 32'(bus.pop), 32'h0);
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    check("mid_rst_pkt_cnt", 32'(bus.pkt_cnt), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("post_rst_busy", 32'(bus.busy), 32'h0);
    check("post_rst_pkt_cnt", 32'(bus.pkt_cnt), 32'h0);

    // Counter wrap: preload 16'hFFFF, one delivery wraps to 0.
    force dut.pkt_cnt_q = 16'hFFFF;
    tick();
    release dut.pkt_cnt_q;
    tick();
    check("wrap_preload", 32'(bus.pkt_cnt), 32'hFFFF);
    expect_pkt(1, 4'b1000, 16'h0300, 1'b0);
    enqueue(1, 16'h0300);
    repeat (5) tick();
    check("wrap_pkt_cnt", 32'(bus.pkt_cnt), 32'h0);

    check("sb_pops_left", exp_src_q.size(), 32'h0);
    check("sb_pushes_left", exp_mask_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_rr_scheduler.md
Name: bus_rr_scheduler

Overview:
Round-robin scheduler/router for the shared data bus between `drvrs` driver FIFOs.
- Picks one pending source, pops its head packet and decodes the destination ID from the packet header.
- Pushes the packet to the destination FIFO, or to all FIFOs except the source for broadcast.
- Sits between the per-driver FIFOs and the bus, in the same position as the bus generator/arbiter.

Parameters:
- drvrs, 4, number of drivers/FIFOs; range 2..16.
- pckg_sz, 16, packet width in bits; must be at least ID_W+1.
- broadcast, 8'hFF, header ID value that means broadcast.
- ID_W, 8, header ID width, taken from D_pop[pckg_sz-1 -: ID_W].
- GAP, 0, idle cycles inserted after each transfer; range 0..15.

Ports:
- clk  input  1  bus clock
- reset  input  1  asynchronous, active-low reset
- pndng  input  drvrs  per-driver FIFO not-empty
- D_pop  input  drvrs*pckg_sz  head packet of each FIFO; driver i at [i*pckg_sz +: pckg_sz]
- pop  output  drvrs  one-hot pop strobe, one cycle long
- push  output  drvrs  destination push mask, one cycle long
- D_push  output  pckg_sz  packet broadcast to all FIFO inputs
- grant_id  output  4  index of the current/last granted driver
- busy  output  1  high when state != IDLE
- err  output  1  one-cycle pulse on an invalid destination
- pkt_cnt  output  16  number of delivered packets; wraps at 16'hFFFF -> 0

Behaviour:
- Reset: while reset=0, asynchronously force every output to 0, state=IDLE, rr_ptr=drvrs-1 so driver 0 wins first, gap counter=0. Reset mid-transfer abandons the packet; no partial push or pop strobe may appear after reset is released.
- FSM states are IDLE, GRANT, PUSH, GAP.
- IDLE:
  - If pndng != 0, pick the winner: the first set bit searching from rr_ptr+1 upward, mod drvrs.
  - Register the winner into grant_id and go to GRANT.
  - If pndng == 0, stay in IDLE.
- GRANT (1 cycle):
  - pop[grant_id]=1.
  - Capture D_pop slice grant_id into pkt_q; head data is valid while pndng is high.
  - rr_ptr <= grant_id. Go to PUSH.
- PUSH (1 cycle):
  - D_push=pkt_q. Let dst = pkt_q[pckg_sz-1 -: ID_W].
  - dst == broadcast: push = all ones with bit grant_id cleared.
  - dst < drvrs: push = one-hot(dst). Self-addressing is allowed.
  - Otherwise: push=0 and err=1.
  - pkt_cnt increments only when push != 0.
  - Go to GAP if GAP>0, else IDLE.
- GAP: count GAP cycles, then go to IDLE. pndng is ignored during GAP.
- Latency: pndng rising in cycle N gives pop in N+1 and push in N+2. Minimum period is 3+GAP cycles per packet.
- D_push holds its last value outside PUSH. push and pop are never high in the same cycle.
- Fairness: with all sources continuously pending, grants rotate 0,1,...,drvrs-1,0. No source waits more than drvrs-1 grants.
- A pndng bit dropping between IDLE and GRANT is a FIFO protocol violation. The packet is still popped and captured; no special handling.
- All outputs are registered except D_push, which is driven directly from pkt_q.

Decomposition:
- Package bus_sched_pkg holds:
  - the state_t enum {IDLE, GRANT, PUSH, GAP};
  - the ID_W localparam;
  - a function that builds the destination mask from (dst, src, drvrs, broadcast).
- Sub-module rr_arbiter: combinational rotate-priority pick.
  - Inputs: req[drvrs], ptr.
  - Outputs: gnt_idx, gnt_valid.
  - The parent registers its outputs.

Test Plan:
1. Reset held low for 3 cycles, with pndng=4'b1111 -> pop, push, err, busy and pkt_cnt all 0. After release, the first grant goes to driver 0.
2. Driver 2 pending with D_pop[2]=16'h01AB -> pop=4'b0100 in cycle N+1; push=4'b0010 and D_push=16'h01AB in N+2; pkt_cnt=1.
3. Driver 1 sends 16'hFF55 (broadcast) -> push=4'b1101 for exactly one cycle; err=0.
4. All four drivers pending, 8 packets, GAP=0 -> grant sequence 0,1,2,3,0,1,2,3; pop strobes 3 cycles apart.
5. Driver 3 sends 16'h07AA, where dst 7 >= drvrs -> push=0, err=1 for one cycle, pkt_cnt unchanged, FIFO still popped.
6. reset asserted during PUSH -> push goes to 0 immediately (asynchronously). After release the FSM restarts in IDLE. Separately, preload pkt_cnt at 16'hFFFF; one more delivery -> pkt_cnt=0.
